// File: rtl/fp32_fms_arbiter.sv
// Round-robin arbiter sharing one fixed-latency fp32 a*b-c unit, with credit-limited issue
// and an in-order response FIFO. Define FP32_FMS_ARB_PERF_EN to add issue/stall counters.
module fp32_fms_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned FU_LATENCY = 4,
    parameter int unsigned RSP_DEPTH  = 8,
    localparam int unsigned ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [32*NUM_REQ-1:0]  req_a,
    input  logic [32*NUM_REQ-1:0]  req_b,
    input  logic [32*NUM_REQ-1:0]  req_c,
    output logic [31:0]            fu_a,
    output logic [31:0]            fu_b,
    output logic [31:0]            fu_c,
    input  logic [31:0]            fu_result,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [31:0]            rsp_data,
    output logic                   busy
`ifdef FP32_FMS_ARB_PERF_EN
    ,
    output logic [32*NUM_REQ-1:0]  perf_issued,
    output logic [31:0]            perf_stall
`endif
);

    localparam int unsigned PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int unsigned INF_W = $clog2(FU_LATENCY + 1);

    if (RSP_DEPTH < FU_LATENCY) begin : g_depth_chk
        $error("fp32_fms_arbiter: RSP_DEPTH must be >= FU_LATENCY");
    end
    if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_req_chk
        $error("fp32_fms_arbiter: NUM_REQ must be in 2..16");
    end
    if (FU_LATENCY < 1) begin : g_lat_chk
        $error("fp32_fms_arbiter: FU_LATENCY must be >= 1");
    end

    logic [ID_W-1:0]       rr_last;
    logic [ID_W-1:0]       grant_idx;
    logic                  grant_vld;
    logic [31:0]           cand;
    logic                  handshake;
    logic                  credit_ok;
    logic                  issue_en;

    logic [FU_LATENCY-1:0] sh_valid;
    logic [ID_W-1:0]       sh_id [FU_LATENCY];
    logic [INF_W-1:0]      inflight;

    logic [31:0]           mem_data [RSP_DEPTH];
    logic [ID_W-1:0]       mem_id   [RSP_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      fifo_count;
    logic [31:0]           last_data;
    logic [ID_W-1:0]       last_id;
    logic                  push;
    logic                  pop;

    // Credits count both in-flight and buffered results, so a landing result always has room.
    assign credit_ok = (32'(fifo_count) + 32'(inflight)) < RSP_DEPTH;
    assign issue_en  = rst_n & credit_ok;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = (32'(rr_last) + k) % NUM_REQ;
            if (issue_en && !grant_vld && req_valid[ID_W'(cand)]) begin
                grant_vld = 1'b1;
                grant_idx = ID_W'(cand);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        fu_a      = '0;
        fu_b      = '0;
        fu_c      = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_vld && grant_idx == ID_W'(i)) begin
                req_ready[i] = 1'b1;
                fu_a         = req_a[32*i +: 32];
                fu_b         = req_b[32*i +: 32];
                fu_c         = req_c[32*i +: 32];
            end
        end
    end

    assign handshake = |(req_valid & req_ready);

    // Shadow pipeline: last stage lines up with fu_result for the same operation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh_valid <= '0;
            inflight <= '0;
            rr_last  <= ID_W'(NUM_REQ - 1);
        end else begin
            sh_valid[0] <= handshake;
            for (int unsigned s = 1; s < FU_LATENCY; s++) begin
                sh_valid[s] <= sh_valid[s-1];
            end
            inflight <= inflight + INF_W'(handshake) - INF_W'(sh_valid[FU_LATENCY-1]);
            if (handshake) begin
                rr_last <= grant_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        sh_id[0] <= grant_idx;
        for (int unsigned s = 1; s < FU_LATENCY; s++) begin
            sh_id[s] <= sh_id[s-1];
        end
    end

    assign push = sh_valid[FU_LATENCY-1];
    assign pop  = rsp_valid & rsp_ready;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (32'(p) == RSP_DEPTH - 1) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            last_data  <= '0;
            last_id    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr    <= ptr_inc(rd_ptr);
                last_data <= mem_data[rd_ptr];
                last_id   <= mem_id[rd_ptr];
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= fu_result;
            mem_id[wr_ptr]   <= sh_id[FU_LATENCY-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            assert (32'(fifo_count) < RSP_DEPTH)
                else $error("fp32_fms_arbiter: response FIFO overflow");
        end
    end

    // Head is shown while non-empty; otherwise the most recently popped entry is held.
    assign rsp_valid = (fifo_count != '0);
    assign rsp_data  = rsp_valid ? mem_data[rd_ptr] : last_data;
    assign rsp_id    = rsp_valid ? mem_id[rd_ptr]   : last_id;
    assign busy      = (inflight != '0) | (fifo_count != '0);

`ifdef FP32_FMS_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_issued <= '0;
            perf_stall  <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] & req_ready[i]) begin
                    perf_issued[32*i +: 32] <= perf_issued[32*i +: 32] + 32'd1;
                end
            end
            if ((|req_valid) && !credit_ok) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fp32_fms_arbiter.sv
// Self-checking bench for fp32_fms_arbiter: a 4-cycle behavioural FMS unit plus a queue-based
// model of issue order, credit limit and response timing.
module tb_fp32_fms_arbiter;

    localparam int NREQ  = 4;
    localparam int LAT   = 4;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [32*NREQ-1:0]   req_a, req_b, req_c;
    logic [31:0]          fu_a, fu_b, fu_c, fu_result;
    logic                 rsp_valid, rsp_ready;
    logic [1:0]           rsp_id;
    logic [31:0]          rsp_data;
    logic                 busy;
`ifdef FP32_FMS_ARB_PERF_EN
    logic [32*NREQ-1:0]   perf_issued;
    logic [31:0]          perf_stall;
`endif

    fp32_fms_arbiter #(.NUM_REQ(NREQ), .FU_LATENCY(LAT), .RSP_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_c(req_c),
        .fu_a(fu_a), .fu_b(fu_b), .fu_c(fu_c), .fu_result(fu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
`ifdef FP32_FMS_ARB_PERF_EN
        , .perf_issued(perf_issued), .perf_stall(perf_stall)
`endif
    );

    // fp32 <-> real for normal numbers; subnormals flush to zero
    function automatic real f2r(input logic [31:0] x);
        logic [63:0] d;
        if (x[30:23] == 8'd0) return 0.0;
        d = {x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        int e;
        d = $realtobits(r);
        e = int'({21'd0, d[62:52]}) - 896;
        if (r == 0.0 || e <= 0) return {d[63], 31'd0};
        if (e >= 255) return {d[63], 8'hff, 23'd0};
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fms_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [31:0] c);
        return r2f(f2r(a) * f2r(b) - f2r(c));
    endfunction

    // Shared unit: samples operands each edge, result appears LAT cycles later
    logic [31:0] fu_pipe [LAT];
    logic        garb_en;
    logic [31:0] garb_val;
    always @(posedge clk) begin
        fu_pipe[0] <= fms_model(fu_a, fu_b, fu_c);
        for (int s = 1; s < LAT; s++) fu_pipe[s] <= fu_pipe[s-1];
    end
    assign fu_result = garb_en ? garb_val : fu_pipe[LAT-1];

    typedef struct {
        logic [1:0]  id;
        logic [31:0] data;
        int          t;
    } op_t;

    op_t exp_q[$];
    int  cyc;
    int  m_rr;
    int  n_cmp;
    int  n_fail;

    logic [NREQ-1:0] s_ready, m_ready;
    logic            s_valid, m_valid, s_busy, m_busy;
    logic [1:0]      s_id, m_id;
    logic [31:0]     s_data, m_data, s_fa, m_fa;

    function automatic logic [31:0] rand_fp();
        logic [31:0] r;
        int unsigned e;
        r = $urandom;
        e = 124 + $urandom_range(0, 6);
        return {r[31], e[7:0], r[22:0]};
    endfunction

    task automatic rand_ops();
        for (int i = 0; i < NREQ; i++) begin
            req_a[32*i +: 32] = rand_fp();
            req_b[32*i +: 32] = rand_fp();
            req_c[32*i +: 32] = rand_fp();
        end
    endtask

    // One clock: sample DUT mid-cycle, form model expectations, then advance the model
    task automatic cycle();
        int g;
        @(negedge clk);
        s_ready = req_ready;
        s_valid = rsp_valid;
        s_id    = rsp_id;
        s_data  = rsp_data;
        s_busy  = busy;
        s_fa    = fu_a;
        m_busy  = (exp_q.size() != 0);
        m_valid = 1'b0;
        m_id    = '0;
        m_data  = '0;
        if (exp_q.size() != 0) begin
            if (cyc >= exp_q[0].t + LAT + 1) begin
                m_valid = 1'b1;
                m_id    = exp_q[0].id;
                m_data  = exp_q[0].data;
            end
        end
        g = -1;
        if (rst_n && exp_q.size() < DEPTH) begin
            for (int k = 1; k <= NREQ; k++) begin
                if (g < 0 && req_valid[(m_rr + k) % NREQ]) g = (m_rr + k) % NREQ;
            end
        end
        m_ready = (g >= 0) ? NREQ'(1 << g) : '0;
        m_fa    = (g >= 0) ? req_a[32*g +: 32] : 32'h0;
        if (!rst_n) begin
            exp_q.delete();
            m_rr = NREQ - 1;
        end else begin
            if (m_valid && rsp_ready) void'(exp_q.pop_front());
            if (g >= 0) begin
                exp_q.push_back('{2'(g),
                                 fms_model(req_a[32*g +: 32], req_b[32*g +: 32], req_c[32*g +: 32]),
                                 cyc});
                m_rr = g;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain();
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (16) cycle();
    endtask

    task automatic pulse_reset();
        req_valid = '0;
        rst_n     = 1'b0;
        cycle();
        rst_n     = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = '1;
        rsp_ready = 1'b1;
        rand_ops();
        cycle();
        cycle();
        n_cmp++; if (s_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready got=%b exp=0000", s_ready); end
        n_cmp++; if (s_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got=%b exp=0", s_valid); end
        n_cmp++; if (s_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", s_busy); end
        n_cmp++; if (s_fa !== 32'h0) begin n_fail++; $display("FAIL reset_fu_a got=%h exp=0", s_fa); end
        rst_n     = 1'b1;
        req_valid = 4'b1010;
        cycle();
        n_cmp++; if (s_ready !== 4'b0010) begin n_fail++; $display("FAIL reset_first_prio got=%b exp=0010", s_ready); end
        drain();
    endtask

    task automatic test_single_op();
        req_a = {4{32'h3f800000}};
        req_b = {4{32'h40000000}};
        req_c = {4{32'h3f800000}};
        rsp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            req_valid = (k == 0) ? 4'b0100 : 4'b0000;
            cycle();
            if (k == 0) begin
                n_cmp++; if (s_ready !== 4'b0100) begin n_fail++; $display("FAIL single_grant got=%b exp=0100", s_ready); end
                n_cmp++; if (s_fa !== 32'h3f800000) begin n_fail++; $display("FAIL single_fu_a got=%h exp=3f800000", s_fa); end
            end else if (k < 5) begin
                n_cmp++; if (s_valid !== 1'b0) begin n_fail++; $display("FAIL single_early k=%0d got=%b exp=0", k, s_valid); end
                n_cmp++; if (s_busy !== 1'b1) begin n_fail++; $display("FAIL single_busy k=%0d got=%b exp=1", k, s_busy); end
            end else if (k == 5) begin
                n_cmp++; if ({s_valid, s_id, s_data} !== {1'b1, 2'd2, 32'h3f800000}) begin
                    n_fail++; $display("FAIL single_rsp got=v%b id%0d %h exp=v1 id2 3f800000", s_valid, s_id, s_data);
                end
            end else if (k == 6) begin
                n_cmp++; if ({s_valid, s_busy} !== 2'b00) begin n_fail++; $display("FAIL single_idle got=v%b b%b exp=00", s_valid, s_busy); end
            end
        end
    endtask

    task automatic test_round_robin();
        pulse_reset();
        rsp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            req_valid = '1;
            rand_ops();
            cycle();
            n_cmp++; if (s_ready !== 4'(1 << (k % 4))) begin n_fail++; $display("FAIL rr_order k=%0d got=%b exp=%b", k, s_ready, 4'(1 << (k % 4))); end
            n_cmp++; if (s_fa !== m_fa) begin n_fail++; $display("FAIL rr_fu_a k=%0d got=%h exp=%h", k, s_fa, m_fa); end
        end
        req_valid = '0;
        for (int k = 0; k < 12; k++) begin
            cycle();
            n_cmp++; if (s_valid !== m_valid) begin n_fail++; $display("FAIL rr_rsp_valid k=%0d got=%b exp=%b", k, s_valid, m_valid); end
            if (m_valid) begin
                n_cmp++; if ({s_id, s_data} !== {m_id, m_data}) begin n_fail++; $display("FAIL rr_rsp k=%0d got=%0d/%h exp=%0d/%h", k, s_id, s_data, m_id, m_data); end
            end
        end
        drain();
    endtask

    task automatic test_backpressure();
        int hs;
        hs = 0;
        rsp_ready = 1'b0;
        for (int k = 0; k < 14; k++) begin
            req_valid = '1;
            rand_ops();
            cycle();
            hs += $countones(s_ready);
            n_cmp++; if (s_ready !== m_ready) begin n_fail++; $display("FAIL bp_ready k=%0d got=%b exp=%b", k, s_ready, m_ready); end
            if (m_valid) begin
                n_cmp++; if ({s_valid, s_id, s_data} !== {1'b1, m_id, m_data}) begin n_fail++; $display("FAIL bp_head k=%0d got=%b/%0d/%h exp=1/%0d/%h", k, s_valid, s_id, s_data, m_id, m_data); end
            end
        end
        n_cmp++; if (hs !== 8) begin n_fail++; $display("FAIL bp_handshakes got=%0d exp=8", hs); end
        n_cmp++; if (s_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_stalled got=%b exp=0000", s_ready); end
        rsp_ready = 1'b1;
        cycle();
        n_cmp++; if ({s_valid, s_ready} !== {1'b1, 4'b0000}) begin n_fail++; $display("FAIL bp_pop_cycle got=v%b r%b exp=v1 r0000", s_valid, s_ready); end
        rsp_ready = 1'b0;
        cycle();
        n_cmp++; if ($countones(s_ready) !== 1) begin n_fail++; $display("FAIL bp_one_credit got=%b exp=one-hot", s_ready); end
        cycle();
        n_cmp++; if (s_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_restall got=%b exp=0000", s_ready); end
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            cycle();
            n_cmp++; if (s_valid !== m_valid) begin n_fail++; $display("FAIL bp_drain_valid k=%0d got=%b exp=%b", k, s_valid, m_valid); end
            if (m_valid) begin
                n_cmp++; if ({s_id, s_data} !== {m_id, m_data}) begin n_fail++; $display("FAIL bp_drain k=%0d got=%0d/%h exp=%0d/%h", k, s_id, s_data, m_id, m_data); end
            end
        end
    endtask

    task automatic test_push_pop();
        int pops;
        pops = 0;
        rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req_valid = 4'(1 << $urandom_range(0, 3));
            rand_ops();
            cycle();
        end
        req_valid = '0;
        repeat (6) cycle();
        rsp_ready = 1'b1;
        for (int k = 0; k < 28; k++) begin
            req_valid = 4'($urandom_range(1, 15));
            rand_ops();
            cycle();
            n_cmp++; if ({s_valid, s_ready} !== {m_valid, m_ready}) begin n_fail++; $display("FAIL pp_ctrl k=%0d got=v%b r%b exp=v%b r%b", k, s_valid, s_ready, m_valid, m_ready); end
            if (m_valid) begin
                pops++;
                n_cmp++; if ({s_id, s_data} !== {m_id, m_data}) begin n_fail++; $display("FAIL pp_order k=%0d got=%0d/%h exp=%0d/%h", k, s_id, s_data, m_id, m_data); end
            end
        end
        n_cmp++; if (pops < 20) begin n_fail++; $display("FAIL pp_pop_count got=%0d exp>=20", pops); end
        drain();
    endtask

    task automatic test_reset_midflight();
        rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req_valid = '1;
            rand_ops();
            cycle();
        end
        pulse_reset();
        for (int k = 0; k < 10; k++) begin
            cycle();
            n_cmp++; if ({s_valid, s_busy} !== 2'b00) begin n_fail++; $display("FAIL mid_reset_quiet k=%0d got=v%b b%b exp=00", k, s_valid, s_busy); end
        end
        req_valid = '1;
        rand_ops();
        cycle();
        n_cmp++; if (s_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_reset_prio got=%b exp=0001", s_ready); end
        drain();
    endtask

    task automatic test_garbage();
        garb_en   = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            garb_val = (k % 2 == 0) ? 32'h7fc00001 : 32'hxxxxxxxx;
            cycle();
            n_cmp++; if ({s_valid, s_busy} !== 2'b00) begin n_fail++; $display("FAIL garbage k=%0d got=v%b b%b exp=00", k, s_valid, s_busy); end
        end
        garb_en = 1'b0;
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++) begin
            req_valid = 4'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            rand_ops();
            cycle();
            n_cmp++; if (s_ready !== m_ready) begin n_fail++; $display("FAIL rnd_ready k=%0d got=%b exp=%b", k, s_ready, m_ready); end
            n_cmp++; if ({s_valid, s_busy} !== {m_valid, m_busy}) begin n_fail++; $display("FAIL rnd_status k=%0d got=v%b b%b exp=v%b b%b", k, s_valid, s_busy, m_valid, m_busy); end
            n_cmp++; if (s_fa !== m_fa) begin n_fail++; $display("FAIL rnd_fu_a k=%0d got=%h exp=%h", k, s_fa, m_fa); end
            if (m_valid) begin
                n_cmp++; if ({s_id, s_data} !== {m_id, m_data}) begin n_fail++; $display("FAIL rnd_rsp k=%0d got=%0d/%h exp=%0d/%h", k, s_id, s_data, m_id, m_data); end
            end
        end
        drain();
    endtask

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        cyc       = 0;
        m_rr      = NREQ - 1;
        garb_en   = 1'b0;
        garb_val  = '0;
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        req_a     = '0;
        req_b     = '0;
        req_c     = '0;
        test_reset();
        test_single_op();
        test_round_robin();
        test_backpressure();
        test_push_pop();
        test_reset_midflight();
        test_garbage();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fp32_fms_arbiter.md
Name: fp32_fms_arbiter

Overview:
- Shares one fixed-latency fp32 fused multiply-subtract unit (result = a*b - c; no valid, no stall) among NUM_REQ requesters.
- Per cycle: round-robin grant of at most one request, drives that request's operands into the unit, and tracks valid/requester-ID through a shadow pipeline matched to the unit latency.
- Completed results are buffered in a response FIFO with valid/ready backpressure.
- Issue is credit-limited so an in-flight result never finds the FIFO full.

Parameters:
- NUM_REQ, 4, number of requesters (2..16); localparam ID_W = clog2(NUM_REQ), minimum 1.
- FU_LATENCY, 4, cycles from operands sampled by the unit to result valid on fu_result.
- RSP_DEPTH, 8, response FIFO entries; must be >= FU_LATENCY (elaboration error otherwise).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  NUM_REQ  per-requester operation valid
- req_ready  out  NUM_REQ  per-requester grant; one-hot or zero
- req_a  in  32*NUM_REQ  operand a, requester i at [32*i+31:32*i]
- req_b  in  32*NUM_REQ  operand b, same packing
- req_c  in  32*NUM_REQ  operand c, same packing
- fu_a  out  32  operand a to the shared unit
- fu_b  out  32  operand b to the shared unit
- fu_c  out  32  operand c to the shared unit
- fu_result  in  32  result from the shared unit
- rsp_valid  out  1  response FIFO not empty
- rsp_ready  in  1  consumer accepts head
- rsp_id  out  ID_W  requester index of head result
- rsp_data  out  32  head result
- busy  out  1  any operation in flight or buffered

Behaviour:
- Reset (rst_n low at posedge):
  - shadow valid pipeline cleared; FIFO pointers and count = 0; rr_last = NUM_REQ-1, so requester 0 has first priority.
  - Outputs during and after reset: req_ready = 0 (while rst_n low), rsp_valid = 0, busy = 0, fu_* = 0.
- Reset mid-operation: all in-flight and buffered operations are dropped silently. Results the unit emits later are ignored because shadow valids are 0.
- Credit: inflight = popcount of the shadow valid pipeline (registered). can_issue = (fifo_count + inflight) < RSP_DEPTH, using registered values only. A pop in the same cycle does not free a credit until the next cycle.
- Arbitration (combinational):
  - If can_issue, grant the first i with req_valid[i], searching from rr_last+1 upward with wrap-around.
  - req_ready = onehot(grant), else 0. req_ready may depend on req_valid.
  - Handshake: req_valid[i] & req_ready[i]. On handshake, rr_last <= i; otherwise rr_last holds.
- Operand mux: fu_a/fu_b/fu_c = the granted requester's operands; 32'h0 when there is no grant. The unit samples them at the end of the grant cycle T.
- Shadow pipeline: FU_LATENCY stages of {valid, id}. Stage 0 is loaded at the end of cycle T with {handshake, grant index}. The last stage is aligned with fu_result valid in cycle T+FU_LATENCY.
- FIFO write: when the last shadow stage is valid, {id, fu_result} is written at the end of cycle T+FU_LATENCY. The credit rule guarantees no write ever occurs when full; assert in simulation.
- Latency: earliest rsp_valid is cycle T+FU_LATENCY+1 (5 with defaults). Ordering is strict global issue order.
- FIFO read:
  - Pop on rsp_valid & rsp_ready.
  - rsp_id/rsp_data show the head entry and are stable while rsp_valid & !rsp_ready.
  - Simultaneous push and pop: count unchanged, both pointers advance (mod RSP_DEPTH, RSP_DEPTH need not be a power of 2).
  - Empty: rsp_valid = 0; rsp_data/rsp_id hold the last value.
- busy = (inflight != 0) | (fifo_count != 0).
- Special values (NaN, inf, zero) pass through untouched; the arbiter never inspects data.

Optional Feature:
- Macro FP32_FMS_ARB_PERF_EN.
- Defined: adds outputs perf_issued (32*NUM_REQ, per-requester handshake counters) and perf_stall (32, counts cycles with a nonzero req_valid but can_issue = 0). Both counters reset to 0 and wrap at 2^32.
- Undefined: those ports and their counters do not exist; all other behaviour is identical.

Test Plan:
- Single op: requester 2 issues a=3f800000, b=40000000, c=3f800000 in cycle 0 (fu_result modelled by a 4-cycle reference model) -> rsp_valid in cycle 5 with rsp_id=2, rsp_data=3f800000; busy low from cycle 6 when rsp_ready=1.
- Round-robin: all 4 req_valid held high for 8 cycles, rsp_ready=1 -> grant order 0,1,2,3,0,1,2,3; responses arrive in that order.
- Backpressure: rsp_ready=0, all requesters valid -> exactly 8 handshakes, then req_ready=0. After rsp_ready=1 for one cycle, exactly one new grant occurs on the following cycle; no FIFO overflow assertion fires.
- Simultaneous push/pop with FIFO at count 3 -> count stays 3; data order preserved across pointer wrap after 20 ops.
- Reset mid-flight: 3 ops issued, rst_n low for 1 cycle at cycle 2 -> rsp_valid stays 0 for 10 cycles afterward; next issue goes to requester 0.
- Garbage isolation: fu_result driven X/NaN 7fc00001 on cycles with no shadow valid -> no FIFO write and no rsp_valid.
